// File: rtl/fetch_responder_pkg.sv
// Shared types for fetch_responder: state encoding, port bundles and register record.
// Also read by the optional FETCH_RESP_NEXTLINE_EN build of the top.
package fetch_responder_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned WADDR_W  = 30;
  localparam int unsigned COUNT_W  = 4;
  localparam int unsigned MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2
  } fetch_resp_state;

  typedef struct packed {
    logic            mem_valid;
    logic [XLEN-1:0] mem_addr;
    logic            flush;
    logic [XLEN-1:0] ram_rdata;
  } fetch_resp_in_type;

  // ram_addr carries the full word address; the top trims it to ram_depth bits
  typedef struct packed {
    logic               mem_ready;
    logic [XLEN-1:0]    mem_rdata;
    logic               ram_en;
    logic [WADDR_W-1:0] ram_addr;
  } fetch_resp_out_type;

  typedef struct packed {
    fetch_resp_state    state;
    logic [COUNT_W-1:0] count;
    logic [WADDR_W-1:0] addr;
  } fetch_resp_reg_type;

  function automatic logic [WADDR_W-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
    return byte_addr[XLEN-1:2];
  endfunction

endpackage

// File: rtl/fetch_responder.sv
// Memory-side fetch responder in front of a 1-cycle-latency instruction SRAM with
// programmable wait states. Optional one-entry next-line buffer: FETCH_RESP_NEXTLINE_EN.
module fetch_responder
  import fetch_responder_pkg::*;
#(
  parameter int unsigned wait_states = 0,
  parameter int unsigned ram_depth   = 14
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_addr,
  input  logic                 flush,
  output logic                 mem_ready,
  output logic [31:0]          mem_rdata,
  output logic                 ram_en,
  output logic [ram_depth-1:0] ram_addr,
  input  logic [31:0]          ram_rdata
);

  localparam bit                 NO_WAIT   = (wait_states == 0);
  localparam logic [COUNT_W-1:0] WAIT_INIT = COUNT_W'(wait_states);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);
  localparam logic [WADDR_W-1:0] WORD_ONE  = WADDR_W'(1);

  if (wait_states > MAX_WAIT) begin : g_bad_wait_states
    $error("fetch_responder: wait_states must be in 0..15");
  end
  if (ram_depth < 1 || ram_depth >= WADDR_W) begin : g_bad_ram_depth
    $error("fetch_responder: ram_depth must be in 1..29");
  end

  fetch_resp_in_type  din;
  fetch_resp_out_type dout;
  fetch_resp_reg_type r_q, r_d;

  logic               req_ok;
  logic               accept;
  logic               hit;
  logic [WADDR_W-1:0] req_word;

`ifdef FETCH_RESP_NEXTLINE_EN
  logic               nl_valid_q, nl_valid_d;
  logic [WADDR_W-1:0] nl_tag_q, nl_tag_d;
  logic [XLEN-1:0]    nl_data_q, nl_data_d;
  logic               fill_q, fill_d;
  logic               hit_q, hit_d;
`endif

  assign din = '{mem_valid: mem_valid, mem_addr: mem_addr, flush: flush, ram_rdata: ram_rdata};

  // Next-state and output logic; flush outranks every transition
  always_comb begin
    r_d           = r_q;
    dout          = '0;
    dout.ram_addr = r_q.addr;
    req_word      = word_addr(din.mem_addr);
    req_ok        = din.mem_valid & ~din.flush;
    accept        = 1'b0;
    hit           = 1'b0;
`ifdef FETCH_RESP_NEXTLINE_EN
    nl_valid_d = nl_valid_q;
    nl_tag_d   = nl_tag_q;
    nl_data_d  = nl_data_q;
    fill_d     = 1'b0;
    hit_d      = 1'b0;
    if (fill_q) begin
      nl_valid_d = 1'b1;
      nl_tag_d   = r_q.addr + WORD_ONE;
      nl_data_d  = din.ram_rdata;
    end
    // a hit during the fill capture would read data that is being overwritten
    hit = req_ok & nl_valid_q & ~fill_q & (nl_tag_q == req_word);
`endif

    unique case (r_q.state)
      IDLE: accept = req_ok;
      WAIT: begin
        if (din.flush) begin
          r_d.state = IDLE;
          r_d.count = '0;
        end else begin
          r_d.count = r_q.count - CNT_ONE;
          if (r_q.count == CNT_ONE) begin
            dout.ram_en = 1'b1;
            r_d.state   = READ;
          end
        end
      end
      READ: begin
        r_d.state = IDLE;
        accept    = req_ok;
        if (!din.flush) begin
          dout.mem_ready = 1'b1;
          dout.mem_rdata = din.ram_rdata;
`ifdef FETCH_RESP_NEXTLINE_EN
          if (hit_q) dout.mem_rdata = nl_data_q;
          if (!req_ok) begin
            fill_d        = 1'b1;
            dout.ram_en   = 1'b1;
            dout.ram_addr = r_q.addr + WORD_ONE;
          end
`endif
        end
      end
      default: r_d.state = IDLE;
    endcase

    if (din.flush) r_d.addr = '0;

    if (accept) begin
      r_d.addr = req_word;
      if (hit) begin
        r_d.state = READ;
`ifdef FETCH_RESP_NEXTLINE_EN
        hit_d = 1'b1;
`endif
      end else if (NO_WAIT) begin
        dout.ram_en   = 1'b1;
        dout.ram_addr = req_word;
        r_d.state     = READ;
      end else begin
        r_d.count = WAIT_INIT;
        r_d.state = WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '{state: IDLE, count: '0, addr: '0};
    end else begin
      r_q <= r_d;
    end
  end

`ifdef FETCH_RESP_NEXTLINE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nl_valid_q <= 1'b0;
      nl_tag_q   <= '0;
      nl_data_q  <= '0;
      fill_q     <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      nl_valid_q <= nl_valid_d;
      nl_tag_q   <= nl_tag_d;
      nl_data_q  <= nl_data_d;
      fill_q     <= fill_d;
      hit_q      <= hit_d;
    end
  end
`endif

  // SRAM request is forced quiet while reset is held, even with mem_valid high
  assign mem_ready = dout.mem_ready;
  assign mem_rdata = dout.mem_rdata;
  assign ram_en    = dout.ram_en & rst;
  assign ram_addr  = rst ? dout.ram_addr[ram_depth-1:0] : '0;

  logic unused_ok;
  assign unused_ok = ^{din.mem_addr[1:0], dout.ram_addr[WADDR_W-1:ram_depth]};

endmodule

// File: tb/tb_fetch_responder.sv
// Directed, table-driven bench for fetch_responder at wait_states 0, 2 and 3.
// Each instance is backed by a functional 1-cycle-latency SRAM model.
module tb_fetch_responder;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic        flush     = 1'b0;

  logic        rdy0, rdy2, rdy3;
  logic [31:0] rdt0, rdt2, rdt3;
  logic        en0, en2, en3;
  logic [13:0] ra0, ra2, ra3;
  logic [31:0] rr0 = '0, rr2 = '0, rr3 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [13:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  fetch_responder #(.wait_states(0), .ram_depth(14)) u_ws0 (
    .rst(rst), .clk(clk), .mem_valid(mem_valid), .mem_addr(mem_addr), .flush(flush),
    .mem_ready(rdy0), .mem_rdata(rdt0), .ram_en(en0), .ram_addr(ra0), .ram_rdata(rr0));
  fetch_responder #(.wait_states(2), .ram_depth(14)) u_ws2 (
    .rst(rst), .clk(clk), .mem_valid(mem_valid), .mem_addr(mem_addr), .flush(flush),
    .mem_ready(rdy2), .mem_rdata(rdt2), .ram_en(en2), .ram_addr(ra2), .ram_rdata(rr2));
  fetch_responder #(.wait_states(3), .ram_depth(14)) u_ws3 (
    .rst(rst), .clk(clk), .mem_valid(mem_valid), .mem_addr(mem_addr), .flush(flush),
    .mem_ready(rdy3), .mem_rdata(rdt3), .ram_en(en3), .ram_addr(ra3), .ram_rdata(rr3));

  // SRAM models: data for an address enabled in cycle t appears in cycle t+1
  always @(posedge clk) begin
    if (en0) rr0 <= word_of(ra0);
    if (en2) rr2 <= word_of(ra2);
    if (en3) rr3 <= word_of(ra3);
  end

  typedef struct {
    int          dut;
    logic        valid;
    logic [31:0] addr;
    logic        flush;
    logic        chk;
    logic        rdy;
    logic [31:0] rdata;
    logic        en;
    logic [13:0] raddr;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input int d, input logic vld, input logic [31:0] a, input logic fl,
                              input logic rdy, input logic [31:0] rd, input logic en,
                              input logic [13:0] ra);
    vec_t e;
    e.dut = d; e.valid = vld; e.addr = a; e.flush = fl; e.chk = 1'b1;
    e.rdy = rdy; e.rdata = rd; e.en = en; e.raddr = ra;
    vq.push_back(e);
  endfunction

  function automatic void pad(input int n);
    vec_t e;
    e.dut = 0; e.valid = 1'b0; e.addr = '0; e.flush = 1'b0; e.chk = 1'b0;
    e.rdy = 1'b0; e.rdata = '0; e.en = 1'b0; e.raddr = '0;
    for (int i = 0; i < n; i++) vq.push_back(e);
  endfunction

  function automatic void cmp(input int idx, input string what, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, what, act, exp);
    end
  endfunction

  task automatic check_vec(input int idx, input vec_t e);
    logic        r, en;
    logic [31:0] d;
    logic [13:0] ra;
    case (e.dut)
      0:       begin r = rdy0; d = rdt0; en = en0; ra = ra0; end
      2:       begin r = rdy2; d = rdt2; en = en2; ra = ra2; end
      default: begin r = rdy3; d = rdt3; en = en3; ra = ra3; end
    endcase
    cmp(idx, "mem_ready", 32'(r), 32'(e.rdy));
    cmp(idx, "mem_rdata", d, e.rdata);
    cmp(idx, "ram_en", 32'(en), 32'(e.en));
    if (e.en) cmp(idx, "ram_addr", 32'(ra), 32'(e.raddr));
  endtask

  initial begin
    // reset held with a request pending: everything quiet
    mem_valid = 1'b1;
    mem_addr  = 32'h40;
    #12;
    cmp(-1, "rst_ready0", 32'(rdy0), 32'd0);
    cmp(-1, "rst_rdata0", rdt0, 32'd0);
    cmp(-1, "rst_en0", 32'(en0), 32'd0);
    cmp(-1, "rst_addr0", 32'(ra0), 32'd0);
    cmp(-1, "rst_ready3", 32'(rdy3), 32'd0);
    @(negedge clk);
    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0;

    // ws=0 sequential stream, address advanced on mem_ready
    add(0, 1, 32'h0, 0, 0, 32'h0, 1, 14'h0);
    add(0, 1, 32'h4, 0, 1, word_of(14'h0), 1, 14'h1);
    add(0, 1, 32'h8, 0, 1, word_of(14'h1), 1, 14'h2);
    add(0, 0, 32'h8, 0, 1, word_of(14'h2), 0, 14'h0);
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    pad(6);
    // ws=2 single fetch
    add(2, 1, 32'h100, 0, 0, 32'h0, 0, 14'h0);
    add(2, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    add(2, 0, 32'h0, 0, 0, 32'h0, 1, 14'h40);
    add(2, 0, 32'h0, 0, 1, word_of(14'h40), 0, 14'h0);
    add(2, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    pad(6);
    // ws=3 flush in WAIT, then new request
    add(3, 1, 32'h300, 0, 0, 32'h0, 0, 14'h0);
    add(3, 0, 32'h0, 1, 0, 32'h0, 0, 14'h0);
    add(3, 1, 32'h200, 0, 0, 32'h0, 0, 14'h0);
    add(3, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    add(3, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    add(3, 0, 32'h0, 0, 0, 32'h0, 1, 14'h80);
    add(3, 0, 32'h0, 0, 1, word_of(14'h80), 0, 14'h0);
    add(3, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    pad(6);
    // ws=0 flush coincident with READ
    add(0, 1, 32'h10, 0, 0, 32'h0, 1, 14'h4);
    add(0, 1, 32'h14, 1, 0, 32'h0, 0, 14'h0);
    add(0, 1, 32'h14, 0, 0, 32'h0, 1, 14'h5);
    add(0, 0, 32'h0, 0, 1, word_of(14'h5), 0, 14'h0);
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    pad(6);
    // ws=2 back-to-back: READ accepts next request into WAIT
    add(2, 1, 32'h8, 0, 0, 32'h0, 0, 14'h0);
    add(2, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    add(2, 0, 32'h0, 0, 0, 32'h0, 1, 14'h2);
    add(2, 1, 32'hC, 0, 1, word_of(14'h2), 0, 14'h0);
    add(2, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    add(2, 0, 32'h0, 0, 0, 32'h0, 1, 14'h3);
    add(2, 0, 32'h0, 0, 1, word_of(14'h3), 0, 14'h0);
    add(2, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    pad(6);
    // ws=0 aliasing of high address bits and ignored byte offset
    add(0, 1, 32'hFFFF_000B, 0, 0, 32'h0, 1, 14'h2);
    add(0, 1, 32'h0001_0004, 0, 1, word_of(14'h2), 1, 14'h1);
    add(0, 0, 32'h0, 0, 1, word_of(14'h1), 0, 14'h0);
    add(0, 0, 32'h0, 0, 0, 32'h0, 0, 14'h0);
    pad(6);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      mem_valid = vq[i].valid;
      mem_addr  = vq[i].addr;
      flush     = vq[i].flush;
      @(negedge clk);
      if (vq[i].chk) check_vec(i, vq[i]);
    end

    // asynchronous reset while ws=3 instance is issuing its SRAM read
    @(posedge clk); #1; mem_valid = 1'b1; mem_addr = 32'h40; flush = 1'b0;
    @(posedge clk); #1; mem_valid = 1'b0; mem_addr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp(-2, "rst_pre_en3", 32'(en3), 32'd1);
    cmp(-2, "rst_pre_addr3", 32'(ra3), 32'h10);
    #2 rst = 1'b0;
    #1;
    cmp(-2, "rst_async_en3", 32'(en3), 32'd0);
    cmp(-2, "rst_async_ready3", 32'(rdy3), 32'd0);
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmp(-3 - k, "rst_stale_ready3", 32'(rdy3), 32'd0);
      cmp(-3 - k, "rst_stale_en3", 32'(en3), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
